// File: rtl/pru_arb_in.sv
// Round-robin arbiter that serialises NP per-port packet requests into a single
// registered downstream packet stage with a valid/ack handshake.
module pru_arb_in #(
   parameter int NP = 4,
   parameter int PW = 128,
   parameter int IW = 2
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [NP-1:0]    portIf_arbIn_vld,
   input  logic [NP*PW-1:0] portIf_arbIn_pkt,
   output logic [NP-1:0]    arbIn_portIf_ack,
   output logic             oArb_vld,
   output logic [PW-1:0]    oArb_pkt,
   output logic [IW-1:0]    oArb_src,
   input  logic             iArb_ack
);

   typedef enum logic {IDLE, BUSY} arbState_e;

   arbState_e     state;
   logic [IW-1:0] rrPtr;
   logic [NP-1:0] eligible;
   logic          anyEligible;
   logic [IW-1:0] winner;
   logic [IW-1:0] nextPtr;
   logic [NP-1:0] grantVec;
   logic [PW-1:0] winnerPkt;

   // The registered ack vector doubles as lastAck: a port still dropping vld
   // in the cycle after its ack must not be granted a second time.
   assign eligible = portIf_arbIn_vld & ~arbIn_portIf_ack;

   // Scan rrPtr, rrPtr+1, ... wrapping at NP; the first eligible port wins.
   always_comb begin : pickWinner
      logic [IW:0] idx;
      anyEligible = 1'b0;
      winner      = '0;
      idx         = '0;
      for (int i = 0; i < NP; i++) begin
         idx = {1'b0, rrPtr} + (IW+1)'(i);
         if (idx >= (IW+1)'(NP)) begin
            idx = idx - (IW+1)'(NP);
         end
         if (!anyEligible && eligible[idx[IW-1:0]]) begin
            anyEligible = 1'b1;
            winner      = idx[IW-1:0];
         end
      end
   end

   assign nextPtr = (winner == IW'(NP-1)) ? '0 : winner + IW'(1);

   always_comb begin
      grantVec         = '0;
      grantVec[winner] = 1'b1;
   end

   always_comb begin
      winnerPkt = '0;
      for (int k = 0; k < NP; k++) begin
         if (winner == IW'(k)) begin
            winnerPkt = portIf_arbIn_pkt[k*PW +: PW];
         end
      end
   end

   // Grant in IDLE, then hold the packet in BUSY until downstream accepts it.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state            <= IDLE;
         rrPtr            <= '0;
         arbIn_portIf_ack <= '0;
         oArb_vld         <= 1'b0;
         oArb_pkt         <= '0;
         oArb_src         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (anyEligible) begin
                  oArb_vld         <= 1'b1;
                  oArb_pkt         <= winnerPkt;
                  oArb_src         <= winner;
                  arbIn_portIf_ack <= grantVec;
                  rrPtr            <= nextPtr;
                  state            <= BUSY;
               end else begin
                  arbIn_portIf_ack <= '0;
               end
            end
            BUSY: begin
               arbIn_portIf_ack <= '0;
               if (iArb_ack) begin
                  oArb_vld <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               state            <= IDLE;
               arbIn_portIf_ack <= '0;
               oArb_vld         <= 1'b0;
            end
         endcase
      end
   end

endmodule
